// File: rtl/decoded_uop_queue_pkg.sv
// Shared defaults and helpers for the decoded micro-op queue between decode and issue.
// Widths derived from the module parameters are computed where the parameters are known.
package decoded_uop_queue_pkg;

    localparam int unsigned DEF_LANE_COUNT    = 2;
    localparam int unsigned DEF_QUEUE_DEPTH   = 8;
    localparam int unsigned DEF_PAYLOAD_WIDTH = 128;
    localparam int unsigned DEF_ID_WIDTH      = 64;

    function automatic int unsigned lane_popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/decoded_uop_queue_flush_point_finder.sv
// Locates the oldest live entry selected for a partial flush:
// rotates the per-index compare vector into age order, masks to occupancy, priority-encodes.
module flush_point_finder #(
    parameter int unsigned queueDepth = 8
) (
    input  logic [$clog2(queueDepth)-1:0]   i_head,
    input  logic [$clog2(queueDepth+1)-1:0] i_count,
    input  logic [queueDepth-1:0]           i_cmpVec,
    output logic [$clog2(queueDepth)-1:0]   o_offset,
    output logic                            o_found
);

    localparam int unsigned PTR_W = $clog2(queueDepth);
    localparam int unsigned CNT_W = $clog2(queueDepth+1);

    logic [queueDepth-1:0] w_live;

    // Bit k of w_live is the entry k positions younger than head, if it is occupied.
    always_comb begin
        w_live = '0;
        for (int unsigned k = 0; k < queueDepth; k++) begin
            w_live[k] = i_cmpVec[i_head + PTR_W'(k)] && (CNT_W'(k) < i_count);
        end
    end

    always_comb begin
        o_found  = 1'b0;
        o_offset = '0;
        for (int unsigned k = 0; k < queueDepth; k++) begin
            if (!o_found && w_live[k]) begin
                o_found  = 1'b1;
                o_offset = PTR_W'(k);
            end
        end
    end

endmodule

// File: rtl/decoded_uop_queue.sv
// Multi-lane in-order buffer between decode and issue with guaranteed-space stall
// and partial flush of younger (wrong-path) entries by major instruction ID.
module decoded_uop_queue
    import decoded_uop_queue_pkg::*;
#(
    parameter int unsigned laneCount               = DEF_LANE_COUNT,
    parameter int unsigned queueDepth              = DEF_QUEUE_DEPTH,
    parameter int unsigned payloadWidth            = DEF_PAYLOAD_WIDTH,
    parameter int unsigned instructionCounterWidth = DEF_ID_WIDTH
) (
    input  logic                                         clock_i,
    input  logic                                         reset_i,
    input  logic [laneCount-1:0]                         enqValid_i,
    input  logic [laneCount*instructionCounterWidth-1:0] enqMajId_i,
    input  logic [laneCount*payloadWidth-1:0]            enqPayload_i,
    output logic                                         stall_o,
    output logic [laneCount-1:0]                         deqValid_o,
    output logic [laneCount*instructionCounterWidth-1:0] deqMajId_o,
    output logic [laneCount*payloadWidth-1:0]            deqPayload_o,
    input  logic [$clog2(laneCount+1)-1:0]               deqCount_i,
    input  logic                                         flush_i,
    input  logic [instructionCounterWidth-1:0]           flushMajId_i,
    output logic [$clog2(queueDepth+1)-1:0]              count_o,
    output logic                                         overflow_o
);

    localparam int unsigned PTR_W = $clog2(queueDepth);
    localparam int unsigned CNT_W = $clog2(queueDepth+1);
    localparam int unsigned IW    = instructionCounterWidth;
    localparam int unsigned PW    = payloadWidth;
    localparam logic [CNT_W-1:0] STALL_ABOVE = CNT_W'(queueDepth - laneCount);

    logic [IW-1:0]    r_majId   [queueDepth];
    logic [PW-1:0]    r_payload [queueDepth];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    logic                  w_stall;
    logic                  w_anyEnq;
    logic                  w_doEnq;
    logic [CNT_W-1:0]      w_enqNum;
    logic [queueDepth-1:0] w_killVec;
    logic [PTR_W-1:0]      w_flushOff;
    logic                  w_flushFound;

    // Stall uses the registered count only, so a full-width enqueue always fits.
    assign w_stall  = r_count > STALL_ABOVE;
    assign w_anyEnq = |enqValid_i;
    assign w_doEnq  = !flush_i && !w_stall && w_anyEnq;
    assign w_enqNum = CNT_W'(lane_popcount(32'(enqValid_i)));

    always_comb begin
        w_killVec = '0;
        for (int unsigned i = 0; i < queueDepth; i++) begin
            w_killVec[i] = r_majId[i] >= flushMajId_i;
        end
    end

    flush_point_finder #(
        .queueDepth (queueDepth)
    ) u_flush_point_finder (
        .i_head   (r_head),
        .i_count  (r_count),
        .i_cmpVec (w_killVec),
        .o_offset (w_flushOff),
        .o_found  (w_flushFound)
    );

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= !flush_i && w_stall && w_anyEnq;
            if (flush_i) begin
                // Head is kept; only the younger tail of the queue is cut back.
                if (w_flushFound) begin
                    r_tail  <= r_head + w_flushOff;
                    r_count <= CNT_W'(w_flushOff);
                end
            end else begin
                r_head  <= r_head + PTR_W'(deqCount_i);
                r_tail  <= r_tail + (w_doEnq ? PTR_W'(w_enqNum) : '0);
                r_count <= r_count + (w_doEnq ? w_enqNum : '0) - CNT_W'(deqCount_i);
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i && w_doEnq) begin
            for (int unsigned k = 0; k < laneCount; k++) begin
                if (enqValid_i[k]) begin
                    r_majId[r_tail + PTR_W'(k)]   <= enqMajId_i[k*IW +: IW];
                    r_payload[r_tail + PTR_W'(k)] <= enqPayload_i[k*PW +: PW];
                end
            end
        end
    end

    always_comb begin
        deqValid_o   = '0;
        deqMajId_o   = '0;
        deqPayload_o = '0;
        for (int unsigned k = 0; k < laneCount; k++) begin
            deqValid_o[k]            = r_count > CNT_W'(k);
            deqMajId_o[k*IW +: IW]   = r_majId[r_head + PTR_W'(k)];
            deqPayload_o[k*PW +: PW] = r_payload[r_head + PTR_W'(k)];
        end
    end

    assign stall_o    = w_stall;
    assign count_o    = r_count;
    assign overflow_o = r_overflow;

endmodule
